// File: rtl/ap_result_collector_pkg.sv
// Shared types and default widths for the AP result collector.
package ap_result_collector_pkg;

  localparam int OUTPORT = 8;
  localparam int N_CORE  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ap_result_fifo.sv
// Capture FIFO; a push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module ap_result_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             empty, push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop_ok};
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ap_result_collector.sv
// Captures AP lane results into a FIFO and drains them to output memory at sequential addresses.
module ap_result_collector
  import ap_result_collector_pkg::*;
#(
  parameter int outport   = OUTPORT,
  parameter int N_core    = N_CORE,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [outport*N_core-1:0] in,
  input  logic [N_core-1:0]         in_en,
  input  logic                      start,
  input  logic [ADDR_BITS-1:0]      base_addr,
  input  logic [ADDR_BITS-1:0]      total,
  output logic [outport*N_core-1:0] wr_data,
  output logic [N_core-1:0]         wr_mask,
  output logic [ADDR_BITS-1:0]      wr_addr,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);
  localparam int DW = outport * N_core;
  localparam int W  = DW + N_core;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, total_q, written_q;
  logic                 overflow_q;

  logic [W-1:0]             f_dout;
  logic [$clog2(DEPTH):0]   f_count;
  logic                     f_full;
  logic                     push, pop, last_pop, flush, head_valid;

  assign push       = (|in_en) & (state_q == BUSY) & ~start;
  assign head_valid = (f_count != '0) & (state_q == BUSY);
  assign pop        = head_valid & wr_ready & ~start;
  assign last_pop   = pop & ((written_q + 1'b1) == total_q);
  // Leftover captures beyond total are discarded as we leave BUSY.
  assign flush      = start | last_pop;

  ap_result_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({in, in_en}),
    .dout  (f_dout),
    .count (f_count),
    .full  (f_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (total == '0) ? DONE : BUSY;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        BUSY:    if (last_pop) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q == BUSY);
    done     = (state_q == DONE);
    overflow = overflow_q;
    wr_valid = head_valid;
    wr_data  = head_valid ? f_dout[W-1 -: DW] : '0;
    wr_mask  = head_valid ? f_dout[N_core-1:0] : '0;
    wr_addr  = base_q + written_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q     <= '0;
      total_q    <= '0;
      written_q  <= '0;
      overflow_q <= 1'b0;
    end else if (start) begin
      base_q     <= base_addr;
      total_q    <= total;
      written_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) written_q <= written_q + 1'b1;
      if (push & f_full & ~pop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_result_collector.sv
// Directed bench: stimulus queues expected write words, a negedge monitor checks every handshake.
module tb_ap_result_collector;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } exp_t;

  logic        clk = 0;
  logic        reset = 0;
  logic [63:0] in = '0;
  logic [7:0]  in_en = '0;
  logic        start = 0;
  logic [15:0] base_addr = '0;
  logic [15:0] total = '0;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic [15:0] wr_addr;
  logic        wr_valid;
  logic        wr_ready = 0;
  logic        busy, done, overflow;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   hs_cnt = 0;

  ap_result_collector dut (
    .clk(clk), .reset(reset), .in(in), .in_en(in_en), .start(start),
    .base_addr(base_addr), .total(total), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Scoreboard monitor: every accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && wr_valid && wr_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", {48'd0, wr_addr}, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hs_addr", {48'd0, wr_addr}, {48'd0, e.addr});
        check("hs_data", wr_data, e.data);
        check("hs_mask", {56'd0, wr_mask}, {56'd0, e.mask});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] t);
    start = 1; base_addr = b; total = t;
    cyc();
    start = 0;
  endtask

  task automatic cap(input logic [63:0] d, input logic [7:0] m, input bit expect_it, input logic [15:0] a);
    in = d; in_en = m;
    if (expect_it) exp_q.push_back('{addr: a, data: d, mask: m});
    cyc();
    in_en = '0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, {63'd0, wr_valid}, 64'd0);
    check({name, "_data"},  wr_data, 64'd0);
    check({name, "_mask"},  {56'd0, wr_mask}, 64'd0);
    check({name, "_addr"},  {48'd0, wr_addr}, 64'd0);
    check({name, "_busy"},  {63'd0, busy}, 64'd0);
    check({name, "_done"},  {63'd0, done}, 64'd0);
    check({name, "_ovf"},   {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    int h0;
    reset = 0;
    repeat (2) cyc();
    check_zero("reset");
    reset = 1;
    cyc();

    // Basic: three words at 0x0100..0x0102
    wr_ready = 1;
    do_start(16'h0100, 16'd3);
    check("basic_busy", {63'd0, busy}, 64'd1);
    cap(64'h0102030405060708, 8'hFF, 1, 16'h0100);
    cap(64'h0102030405060709, 8'hFF, 1, 16'h0101);
    cap(64'h010203040506070A, 8'hFF, 1, 16'h0102);
    cyc();
    check("basic_done", {63'd0, done}, 64'd1);
    cyc();
    check("basic_done_once", {63'd0, done}, 64'd0);
    check("basic_busy_drop", {63'd0, busy}, 64'd0);

    // Backpressure: head stays put while 5 entries queue up
    wr_ready = 0;
    do_start(16'h0200, 16'd5);
    for (int k = 0; k < 5; k++) begin
      cap(64'h1111111111111111 + 64'(k), 8'h01 << k, 1, 16'h0200 + 16'(k));
      check("bp_hold_data", wr_data, 64'h1111111111111111);
      check("bp_hold_addr", {48'd0, wr_addr}, 64'h0200);
      check("bp_hold_mask", {56'd0, wr_mask}, 64'h01);
    end
    h0 = hs_cnt;
    wr_ready = 1;
    repeat (5) cyc();
    check("bp_drain_count", 64'(hs_cnt - h0), 64'd5);
    check("bp_done", {63'd0, done}, 64'd1);

    // Overflow: 17th capture into full FIFO is dropped
    wr_ready = 0;
    do_start(16'h0300, 16'd16);
    for (int k = 0; k < 17; k++)
      cap(64'h3000 + 64'(k), 8'hFF, k < 16, 16'h0300 + 16'(k));
    check("ovf_set", {63'd0, overflow}, 64'd1);
    h0 = hs_cnt;
    wr_ready = 1;
    repeat (16) cyc();
    check("ovf_drain_count", 64'(hs_cnt - h0), 64'd16);
    check("ovf_done", {63'd0, done}, 64'd1);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Full FIFO with simultaneous pop accepts the 17th capture
    wr_ready = 0;
    do_start(16'h0400, 16'd17);
    check("ovf_cleared_by_start", {63'd0, overflow}, 64'd0);
    for (int k = 0; k < 16; k++)
      cap(64'h4000 + 64'(k), 8'hFF, 1, 16'h0400 + 16'(k));
    wr_ready = 1;
    cap(64'h4010, 8'hFF, 1, 16'h0410);
    wr_ready = 0;
    check("full_pop_no_ovf", {63'd0, overflow}, 64'd0);
    h0 = hs_cnt;
    wr_ready = 1;
    repeat (16) cyc();
    check("full_pop_drain", 64'(hs_cnt - h0), 64'd16);
    check("full_pop_done", {63'd0, done}, 64'd1);
    cyc();

    // Captures while IDLE are ignored
    cap(64'h5555, 8'hFF, 0, 16'h0);
    cap(64'h5556, 8'h0F, 0, 16'h0);
    check("idle_no_valid", {63'd0, wr_valid}, 64'd0);
    check("idle_no_ovf", {63'd0, overflow}, 64'd0);

    // Partial lane mask
    do_start(16'h0500, 16'd1);
    cap(64'hA5A5A5A5A5A5A5A5, 8'b1010_0000, 1, 16'h0500);
    cyc();
    check("mask_done", {63'd0, done}, 64'd1);

    // Restart with 4 queued entries
    wr_ready = 0;
    do_start(16'h0600, 16'd10);
    for (int k = 0; k < 4; k++) cap(64'h6000 + 64'(k), 8'hFF, 0, 16'h0);
    check("pre_restart_valid", {63'd0, wr_valid}, 64'd1);
    do_start(16'h0700, 16'd1);
    check("restart_valid", {63'd0, wr_valid}, 64'd0);
    check("restart_addr", {48'd0, wr_addr}, 64'h0700);
    wr_ready = 1;
    cap(64'h7777, 8'h3C, 1, 16'h0700);
    cyc();
    check("restart_done", {63'd0, done}, 64'd1);

    // total = 0 completes immediately
    do_start(16'h0800, 16'd0);
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_busy", {63'd0, busy}, 64'd0);
    cyc();
    check("zero_done_once", {63'd0, done}, 64'd0);

    // Address wrap
    do_start(16'hFFFE, 16'd4);
    cap(64'h9000, 8'hFF, 1, 16'hFFFE);
    cap(64'h9001, 8'hFF, 1, 16'hFFFF);
    cap(64'h9002, 8'hFF, 1, 16'h0000);
    cap(64'h9003, 8'hFF, 1, 16'h0001);
    cyc();
    check("wrap_done", {63'd0, done}, 64'd1);

    // Synchronous reset mid-transfer
    wr_ready = 0;
    do_start(16'h0900, 16'd5);
    for (int k = 0; k < 3; k++) cap(64'hB000 + 64'(k), 8'hFF, 0, 16'h0);
    check("pre_reset_valid", {63'd0, wr_valid}, 64'd1);
    reset = 0;
    cyc();
    check_zero("midreset");
    reset = 1;
    cyc();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
